// File: rtl/band_power.sv
// rtl/band_power.sv - windowed mean-square power of a filtered sample stream
// Sums y*y over 2^WIN_LOG2 samples, then scales, saturates and presents the result on a valid/ready output.
module band_power #(
    parameter int unsigned WIN_LOG2  = 8,
    parameter int unsigned OUT_SHIFT = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic signed [31:0] y,
    input  logic               y_valid,
    output logic               p_valid,
    input  logic               p_ready,
    output logic        [31:0] p_data,
    output logic               overrun,
    input  logic               clr_overrun
);

    localparam int unsigned AW = 64 + WIN_LOG2;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [AW-1:0]         stage_q, stage_d;
    logic                  stage_vld_q, stage_vld_d;
    logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
    logic [31:0]           res_q, res_d;
    logic                  res_vld_q, res_vld_d;
    logic                  p_valid_q, p_valid_d;
    logic [31:0]           p_data_q, p_data_d;
    logic                  overrun_q, overrun_d;

    logic signed [63:0]    y_ext;
    logic signed [63:0]    sq_s;
    logic [AW-1:0]         sum_next;
    logic [AW-1:0]         mean;
    logic [AW-1:0]         val;
    logic                  take;

    // Square is below 2^63, so the low 64 bits of the signed product are exact and non-negative.
    assign y_ext    = 64'(y);
    assign sq_s     = y_ext * y_ext;
    assign sum_next = acc_q + {{WIN_LOG2{1'b0}}, sq_s};
    assign mean     = stage_q >> WIN_LOG2;
    assign val      = mean >> OUT_SHIFT;
    assign take     = (state_q == ACCUM) && en && y_valid;

    always_comb begin
        state_d     = en ? ACCUM : IDLE;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        stage_vld_d = 1'b0;
        res_d       = (|val[AW-1:32]) ? 32'hFFFF_FFFF : val[31:0];
        res_vld_d   = stage_vld_q && en;
        if (!en) begin
            acc_d   = '0;
            cnt_d   = '0;
            stage_d = '0;
        end else if (take) begin
            if (cnt_q == '1) begin
                stage_d     = sum_next;
                stage_vld_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A load always wins over an accepting handshake; it only counts as overrun if the old result was unread.
    always_comb begin
        p_valid_d = p_valid_q;
        p_data_d  = p_data_q;
        overrun_d = overrun_q & ~clr_overrun;
        if (res_vld_q) begin
            p_valid_d = 1'b1;
            p_data_d  = res_q;
            if (p_valid_q && !p_ready) begin
                overrun_d = 1'b1;
            end
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            res_q       <= '0;
            res_vld_q   <= 1'b0;
            p_valid_q   <= 1'b0;
            p_data_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            res_q       <= res_d;
            res_vld_q   <= res_vld_d;
            p_valid_q   <= p_valid_d;
            p_data_q    <= p_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign p_valid = p_valid_q;
    assign p_data  = p_data_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_band_power.sv
// tb/tb_band_power.sv - directed self-checking bench for band_power
// Window of 4 samples, no output shift; expected values are hand-computed mean squares.
module tb_band_power;

    logic               clk;
    logic               reset;
    logic               en;
    logic signed [31:0] y;
    logic               y_valid;
    logic               p_valid;
    logic               p_ready;
    logic        [31:0] p_data;
    logic               overrun;
    logic               clr_overrun;

    int checks;
    int failures;

    band_power #(
        .WIN_LOG2  (2),
        .OUT_SHIFT (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .y           (y),
        .y_valid     (y_valid),
        .p_valid     (p_valid),
        .p_ready     (p_ready),
        .p_data      (p_data),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic send(input logic [31:0] v);
        @(negedge clk);
        y       = v;
        y_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        y_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        en          = 1'b0;
        y           = '0;
        y_valid     = 1'b0;
        p_ready     = 1'b1;
        clr_overrun = 1'b0;
        #12;
        check("rst_p_valid", {31'd0, p_valid}, 32'd0);
        check("rst_p_data", p_data, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        idle();

        // 3,-3,3,-3 -> 9, valid exactly two edges after the last sample
        send(32'd3);
        send(-32'sd3);
        send(32'd3);
        send(-32'sd3);
        check("lat_e0", {31'd0, p_valid}, 32'd0);
        idle();
        check("lat_e1", {31'd0, p_valid}, 32'd0);
        idle();
        check("lat_e2_valid", {31'd0, p_valid}, 32'd1);
        check("basic_data", p_data, 32'd9);
        idle();
        check("basic_accepted", {31'd0, p_valid}, 32'd0);

        // four -2^31 samples: mean 2^62 saturates
        for (int i = 0; i < 4; i++) send(32'h8000_0000);
        idle();
        idle();
        check("sat_valid", {31'd0, p_valid}, 32'd1);
        check("sat_data", p_data, 32'hFFFF_FFFF);
        idle();

        // two windows while consumer stalls -> overwrite and overrun
        p_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'd1);
        send(32'd2);
        send(32'd2);
        check("ovr_first_data", p_data, 32'd1);
        check("ovr_first_flag", {31'd0, overrun}, 32'd0);
        send(32'd2);
        send(32'd2);
        idle();
        idle();
        check("ovr_second_data", p_data, 32'd4);
        check("ovr_valid_held", {31'd0, p_valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        check("ovr_data_stable", p_data, 32'd4);
        @(negedge clk);
        clr_overrun = 1'b0;
        p_ready     = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_drained", {31'd0, p_valid}, 32'd0);

        // eight back-to-back samples of 2 -> two results of 4
        for (int i = 0; i < 6; i++) send(32'd2);
        check("cont_first_valid", {31'd0, p_valid}, 32'd1);
        check("cont_first_data", p_data, 32'd4);
        send(32'd2);
        check("cont_first_taken", {31'd0, p_valid}, 32'd0);
        send(32'd2);
        idle();
        idle();
        check("cont_second_valid", {31'd0, p_valid}, 32'd1);
        check("cont_second_data", p_data, 32'd4);
        check("cont_no_overrun", {31'd0, overrun}, 32'd0);
        idle();

        // partial window of 5s discarded by en=0
        for (int i = 0; i < 3; i++) send(32'd5);
        @(negedge clk);
        y_valid = 1'b0;
        en      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(32'd1);
        idle();
        idle();
        check("disc_no_early", {31'd0, p_valid}, 32'd0);
        send(32'd1);
        idle();
        idle();
        check("disc_valid", {31'd0, p_valid}, 32'd1);
        check("disc_data", p_data, 32'd1);
        idle();

        // async reset mid-window while a result is presented
        p_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'd6);
        idle();
        idle();
        check("pre_rst_data", p_data, 32'd36);
        send(32'd7);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("async_p_valid", {31'd0, p_valid}, 32'd0);
        check("async_p_data", p_data, 32'd0);
        check("async_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        reset   = 1'b1;
        p_ready = 1'b1;
        y_valid = 1'b0;
        @(posedge clk);
        #1;

        // first window after reset counts from zero
        for (int i = 0; i < 4; i++) send(32'd3);
        idle();
        idle();
        check("post_rst_valid", {31'd0, p_valid}, 32'd1);
        check("post_rst_data", p_data, 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
